inv_sub_bytes_seq: RTL and testbench

// - Inverse SubBytes engine for the AES-256 decryption datapath: applies the FIPS-197 InvSBox to all 16 bytes of a 128-bit state.
// - Time-multiplexed: LANES bytes substituted per cycle, 16/LANES cycles per block.
// - Sits between InvShiftRows and AddRoundKey in the decrypt round loop.
// - Counterpart of the forward s_box used by encryption: InvSBox(SBox(x)) == x for all x.

---
 rtl/inv_sub_bytes_seq.sv | 136 +++++++++++++
 tb/tb_inv_sub_bytes_seq.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/inv_sub_bytes_seq.sv
// Inverse SubBytes engine for the AES decrypt round loop.
// Substitutes LANES bytes of a 128-bit state per cycle through the FIPS-197
// InvSBox, taking 16/LANES cycles per block, with valid/ready on both sides.
module inv_sub_bytes_seq #(
  parameter int unsigned LANES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out,
  output logic         busy
);

  localparam int unsigned Steps = 16 / LANES;
  localparam int unsigned CntW  = (Steps > 1) ? $clog2(Steps) : 1;

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("inv_sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
  end

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [127:0]    work_q, work_d;
  logic [127:0]    out_q, out_d;
  logic            last_step;

  // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 = a^2 * a^4 * ... * a^128; maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] r;
    sq = a;
    r  = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  // Inverse affine transform followed by field inversion.
  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    logic [7:0] t;
    t = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
    return gf_inv(t);
  endfunction

  assign last_step = (cnt_q == CntW'(Steps - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (in_valid) state_d = StRun;
      StRun:   if (last_step) state_d = StDone;
      StDone:  if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from the current state; in_ready is held low during reset.
  always_comb begin
    in_ready  = (state_q == StIdle) && !rst;
    out_valid = (state_q == StDone);
    busy      = (state_q != StIdle);
    state_out = out_q;
  end

  // Datapath next state: capture, per-lane substitution, result hand-off.
  always_comb begin
    work_d = work_q;
    cnt_d  = cnt_q;
    out_d  = out_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          work_d = state_in;
          cnt_d  = '0;
        end
      end
      StRun: begin
        // Byte b (byte0 in the MSBs) belongs to step b / LANES.
        for (int b = 0; b < 16; b++) begin
          if (CntW'(b / LANES) == cnt_q) begin
            work_d[8*(15-b) +: 8] = inv_sbox(work_q[8*(15-b) +: 8]);
          end
        end
        cnt_d = last_step ? '0 : cnt_q + 1'b1;
        // The final step's bytes are folded in here so DONE shows the full block.
        if (last_step) out_d = work_d;
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      work_q <= '0;
      out_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      work_q <= work_d;
      out_q  <= out_d;
    end
  end

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// Directed bench for inv_sub_bytes_seq. Five instances (LANES = 1,2,4,8,16)
// share the stimulus; index 2 (LANES=4) is the primary instance.
module tb_inv_sub_bytes_seq;

  localparam int P = 2;  // index of the LANES=4 instance

  // FIPS-197 forward S-box, one 16-byte row per high nibble.
  localparam logic [127:0] SboxRows [16] = '{
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [127:0] VecIn  = 128'h637c777bf26b6fc53001672bfed7ab76;
  localparam logic [127:0] VecOut = 128'h000102030405060708090a0b0c0d0e0f;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         out_ready;
  logic [127:0] state_in;
  logic [4:0]   in_ready;
  logic [4:0]   out_valid;
  logic [4:0]   busy;
  logic [127:0] state_out [5];

  int n_checks = 0;
  int n_fail   = 0;

  for (genvar g = 0; g < 5; g++) begin : g_dut
    inv_sub_bytes_seq #(.LANES(1 << g)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready[g]),
      .state_in  (state_in),
      .out_valid (out_valid[g]),
      .out_ready (out_ready),
      .state_out (state_out[g]),
      .busy      (busy[g])
    );
  end

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
    logic [127:0] row;
    row = SboxRows[x[7:4]] >> (8 * (15 - int'(x[3:0])));
    return row[7:0];
  endfunction

  function automatic logic [127:0] sbox_block(input logic [127:0] s);
    logic [127:0] r;
    logic [127:0] t;
    r = '0;
    for (int b = 0; b < 16; b++) begin
      t = s >> (120 - 8 * b);
      r = {r[119:0], sbox_fwd(t[7:0])};
    end
    return r;
  endfunction

  // Present one block to the primary instance; returns just after the accept edge.
  task automatic send_block(input logic [127:0] blk);
    int k = 0;
    while (!in_ready[P] && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready[P]) check("send_timeout", 128'd0, 128'd1);
    in_valid = 1'b1;
    state_in = blk;
    @(negedge clk);
    in_valid = 1'b0;
    state_in = ~blk;
  endtask

  task automatic wait_out(output logic [127:0] data, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid[P] && lat < 40);
    if (!out_valid[P]) check("wait_out_timeout", 128'd0, 128'd1);
    data = state_out[P];
  endtask

  task automatic wait_all_idle();
    int k = 0;
    while (busy != 5'b0 && k < 60) begin
      @(negedge clk);
      k++;
    end
    if (busy != 5'b0) check("idle_timeout", 128'(busy), 128'd0);
  endtask

  initial begin
    logic [127:0] d;
    logic [127:0] hold;
    logic [127:0] blk;
    logic [127:0] lane_data [5];
    int           lane_lat [5];
    int           lat;
    int           bad_v, bad_d, bad_r;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; state_in = '0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 128'(in_ready[P]), 128'd0);
    check("rst_out_valid", 128'(out_valid[P]), 128'd0);
    check("rst_busy", 128'(busy[P]), 128'd0);
    check("rst_state_out", state_out[P], 128'd0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 128'(in_ready[P]), 128'd1);

    // Latency and result for every lane count.
    send_block(VecIn);
    for (int g = 0; g < 5; g++) lane_lat[g] = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      for (int g = 0; g < 5; g++) begin
        if (out_valid[g] && lane_lat[g] == 0) begin
          lane_lat[g]  = c;
          lane_data[g] = state_out[g];
        end
      end
      if (lane_lat[0] != 0) break;
    end
    for (int g = 0; g < 5; g++) begin
      check($sformatf("latency_lanes%0d", 1 << g), 128'(lane_lat[g]), 128'(16 >> g));
      check($sformatf("data_lanes%0d", 1 << g), lane_data[g], VecOut);
    end

    // All-0x63 block becomes all zeros, out_valid a single-cycle pulse.
    wait_all_idle();
    send_block({16{8'h63}});
    wait_out(d, lat);
    check("x63_latency", 128'(lat), 128'd4);
    check("x63_data", d, 128'd0);
    @(negedge clk);
    check("x63_pulse_drop", 128'(out_valid[P]), 128'd0);

    // Sweep all 256 byte values; the forward S-box must undo each result.
    for (int k = 0; k < 16; k++) begin
      wait_all_idle();
      blk = '0;
      for (int b = 0; b < 16; b++) blk = {blk[119:0], 8'(16 * k + b)};
      send_block(blk);
      wait_out(d, lat);
      check($sformatf("sweep_blk%0d", k), sbox_block(d), blk);
      if (k == 0) check("spot_00", 128'(d[127:120]), 128'h52);
      if (k == 1) check("spot_16", 128'(d[79:72]), 128'hff);
      if (k == 6) check("spot_63", 128'(d[103:96]), 128'h00);
    end

    // Backpressure: hold DONE for 10 cycles while poking in_valid.
    wait_all_idle();
    out_ready = 1'b0;
    send_block(VecIn);
    wait_out(hold, lat);
    check("bp_data", hold, VecOut);
    bad_v = 0; bad_d = 0; bad_r = 0;
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      state_in = {16{8'h00}};
      @(negedge clk);
      if (out_valid[P] !== 1'b1) bad_v++;
      if (state_out[P] !== hold) bad_d++;
      if (in_ready[P] !== 1'b0) bad_r++;
    end
    in_valid = 1'b0;
    check("bp_valid_stable", 128'(bad_v), 128'd0);
    check("bp_data_stable", 128'(bad_d), 128'd0);
    check("bp_in_ready_low", 128'(bad_r), 128'd0);
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_valid", 128'(out_valid[P]), 128'd0);
    check("bp_release_ready", 128'(in_ready[P]), 128'd1);
    send_block({16{8'h52}});
    wait_out(d, lat);
    check("bp_next_latency", 128'(lat), 128'd4);
    check("bp_next_data", d, {16{8'h48}});

    // Reset during the second RUN cycle discards the block.
    wait_all_idle();
    send_block(VecIn);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy", 128'(busy[P]), 128'd0);
    check("midrst_out_valid", 128'(out_valid[P]), 128'd0);
    check("midrst_state_out", state_out[P], 128'd0);
    check("midrst_in_ready", 128'(in_ready[P]), 128'd0);
    rst = 1'b0;
    bad_v = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid != 5'b0) bad_v++;
    end
    check("midrst_no_stale", 128'(bad_v), 128'd0);
    send_block(VecIn);
    wait_out(d, lat);
    check("midrst_next_latency", 128'(lat), 128'd4);
    check("midrst_next_data", d, VecOut);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
